i2c_cfg_sequencer: RTL and testbench
====================================

# i2c_cfg_sequencer

Sequences register transactions into the single-transaction I2C register block (`enable`/`done`, `is_read`, `chip_addr`/`reg_addr`/`value`, `data`, `i2c_ack_error`) that drives the HDMI transmitter.
- Walks an external configuration table of register writes after power-up, retrying NACKed writes.
- Then periodically polls the transmitter's hot-plug status register.
- On a new hot-plug rising edge, or a `restart` pulse, re-runs the full table.
- Sits between the top-level reset/clock logic and the I2C block; it is the block's only requester.

## Interface
Parameters:
- CHIP_ADDR, 7'h39, 7-bit I2C address used for every transaction
- TABLE_DEPTH, 64, table entries; `rom_addr` width = clog2(TABLE_DEPTH)
- MAX_RETRIES, 3, attempts per entry before error
- STARTUP_CYCLES, 1000000, clocks waited after reset before the first table pass
- POLL_CYCLES, 5400000, clocks between hot-plug polls
- HPD_REG, 8'h42, status register polled; hot-plug = bit 6

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low
- restart  in  1  one-cycle pulse; forces a new table pass at the next idle point
- rom_addr  out  clog2(TABLE_DEPTH)  table index
- rom_data  in  16  {reg_addr[15:8], value[7:0]}, valid 1 clk after `rom_addr` changes; reg_addr 8'hFF = end marker
- i2c_enable  out  1  one-cycle transaction request
- i2c_is_read  out  1  1 = read; held stable for the whole transaction
- i2c_chip_addr  out  7  always CHIP_ADDR
- i2c_reg_addr  out  8  register address
- i2c_value  out  8  write data
- i2c_done  in  1  high when the I2C block is idle
- i2c_data  in  8  read result, valid when `i2c_done` returns high
- i2c_ack_error  in  1  NACK flag, sampled when `i2c_done` returns high
- config_done  out  1  last table pass completed without error
- cfg_error  out  1  an entry exhausted its retries
- hpd  out  1  last polled hot-plug bit

## Operation
States: S_STARTUP, S_FETCH, S_FETCH_WAIT, S_ISSUE, S_WAIT_LOW, S_WAIT_HIGH, S_CHECK, S_POLL_WAIT, S_POLL_ISSUE, S_POLL_LOW, S_POLL_HIGH.

- **Reset.**
  - All outputs are 0, except `i2c_chip_addr` = CHIP_ADDR.
  - State = S_STARTUP; counters are cleared.
  - Reset mid-transaction abandons it immediately; the I2C block is reset by the same signal.
- **S_STARTUP.** Counts STARTUP_CYCLES, then clears `rom_addr`, `config_done` and `cfg_error`, and enters S_FETCH.
- **S_FETCH → S_FETCH_WAIT.** Drives `rom_addr`, then waits the 1-cycle ROM latency.
  - If reg_addr == 8'hFF: sets `config_done` = ~`cfg_error` and goes to S_POLL_WAIT.
  - Else: latches reg/value, clears the retry count, goes to S_ISSUE.
- **S_ISSUE.** Sets `i2c_is_read` = 0 and drives reg/value; `i2c_enable` = 1 for exactly this cycle → S_WAIT_LOW.
- **S_WAIT_LOW.** Waits for `i2c_done` == 0 (transaction accepted) → S_WAIT_HIGH.
- **S_WAIT_HIGH.** Waits for `i2c_done` == 1 → S_CHECK.
- **S_CHECK.**
  - If `i2c_ack_error` == 0: `rom_addr`+1, then S_FETCH.
  - Else: retry count +1.
    - If count < MAX_RETRIES: back to S_ISSUE with the same entry.
    - Otherwise: set `cfg_error`, skip the entry (`rom_addr`+1), then S_FETCH.
- **Wrap.** If `rom_addr` reaches TABLE_DEPTH-1 with no end marker, that entry is processed and the pass ends as if a marker followed; `rom_addr` never wraps to 0 within a pass.
- **S_POLL_WAIT.** Counts POLL_CYCLES → S_POLL_ISSUE.
  - A `restart` pulse here (or latched earlier in the pass) restarts the pass immediately: `rom_addr` = 0, flags cleared, S_FETCH.
  - `restart` during a transaction is latched and honoured at the next S_POLL_WAIT entry.
- **S_POLL_ISSUE.** Sets `i2c_is_read` = 1, `i2c_reg_addr` = HPD_REG, pulses `i2c_enable` → S_POLL_LOW → S_POLL_HIGH (same handshake as writes).
- **S_POLL_HIGH, on `i2c_done` high.**
  - If ack_error: `hpd` is unchanged; back to S_POLL_WAIT.
  - Else: `hpd` ← `i2c_data[6]`. On a 0→1 transition, start a new table pass (S_FETCH, `rom_addr` = 0, flags cleared); otherwise back to S_POLL_WAIT.
- **Read clean-up.** `i2c_is_read` returns to 0 only on entering S_ISSUE.

## Timing
- `i2c_enable` is high for exactly one cycle per transaction and never while `i2c_done` == 0.
- `i2c_is_read`, `i2c_reg_addr` and `i2c_value` are stable from the `i2c_enable` cycle until `i2c_done` rises.
- Table entry overhead: FETCH + FETCH_WAIT + ISSUE + CHECK = 4 clocks, plus I2C bus time.
- Retry reissue: 1 clock after S_CHECK.
- `config_done` and `cfg_error` are registered and update in the cycle after the end marker is seen / the error is detected.
- `hpd` updates the cycle after `i2c_done` rises on a poll.

## Test plan
- **Table pass.** Table {(0x41,0x10), (0x98,0x03), (0xFF,–)}, I2C model always ACKs → exactly 2 write transactions in order, with one-cycle enables; `config_done` = 1, `cfg_error` = 0.
- **Recovered NACK.** NACK the 1st attempt of 0x98 only → 0x98 is issued twice; `config_done` = 1.
- **Exhausted retries.** NACK 0x41 always (MAX_RETRIES = 3) → 3 attempts, `cfg_error` = 1, 0x98 still written, `config_done` = 0.
- **Hot-plug.** Poll returns 0x00, then 0x40 → `hpd` 0→1 and a full table re-run starts; the next poll at 0x40 does not re-run.
- **Restart and reset.** `restart` pulsed mid-write → the current write completes, then rerun at S_POLL_WAIT entry. `reset` low mid-transaction → `i2c_enable` = 0, `config_done` = 0, S_STARTUP count restarts.
- **No end marker.** Table with no 0xFF and TABLE_DEPTH = 4 → 4 writes, then polling; `rom_addr` never exceeds 3.

Source files
------------

// File: rtl/i2c_cfg_sequencer.sv
// i2c_cfg_sequencer
//
// Sole requester of the single-transaction I2C register block that drives the
// HDMI transmitter. After power-up it walks an external configuration table of
// register writes, retrying NACKed writes. When the table is done, it polls
// the transmitter's hot-plug status register at a fixed interval. A new
// hot-plug rising edge, or a restart pulse, re-runs the whole table.
//
// Ports
//   clk            system clock
//   reset          synchronous, active-low
//   restart        one-cycle pulse; new table pass at the next idle point
//   rom_addr       table index (registered)
//   rom_data       {reg_addr, value}, valid 1 clk after rom_addr changes;
//                  reg_addr 8'hFF marks the end of the table
//   i2c_enable     one-cycle transaction request
//   i2c_is_read    1 = read; held for the whole transaction
//   i2c_chip_addr  constant CHIP_ADDR
//   i2c_reg_addr   register address (HPD_REG while a poll is outstanding)
//   i2c_value      write data
//   i2c_done       high while the I2C block is idle
//   i2c_data       read result, valid when i2c_done returns high
//   i2c_ack_error  NACK flag, valid when i2c_done returns high
//   config_done    last table pass completed without error
//   cfg_error      an entry exhausted its retries in the last pass
//   hpd            last successfully polled hot-plug bit
//
// Handshake with the I2C block: i2c_enable is a one-cycle request that is only
// raised when i2c_done is high. i2c_done going low means the request was
// accepted; i2c_done going high again means it finished, and i2c_ack_error /
// i2c_data are sampled on that cycle. Request fields stay constant from the
// enable cycle until completion.
//
// STARTUP_CYCLES and POLL_CYCLES must be at least 1.

module i2c_cfg_sequencer #(
  parameter logic [6:0] CHIP_ADDR      = 7'h39,
  parameter int         TABLE_DEPTH    = 64,
  parameter int         MAX_RETRIES    = 3,
  parameter int         STARTUP_CYCLES = 1000000,
  parameter int         POLL_CYCLES    = 5400000,
  parameter logic [7:0] HPD_REG        = 8'h42,
  localparam int        AW             = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          restart,
  output logic [AW-1:0] rom_addr,
  input  logic [15:0]   rom_data,
  output logic          i2c_enable,
  output logic          i2c_is_read,
  output logic [6:0]    i2c_chip_addr,
  output logic [7:0]    i2c_reg_addr,
  output logic [7:0]    i2c_value,
  input  logic          i2c_done,
  input  logic [7:0]    i2c_data,
  input  logic          i2c_ack_error,
  output logic          config_done,
  output logic          cfg_error,
  output logic          hpd
);

  typedef enum logic [3:0] {
    S_STARTUP,
    S_FETCH,
    S_FETCH_WAIT,
    S_ISSUE,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_CHECK,
    S_POLL_WAIT,
    S_POLL_ISSUE,
    S_POLL_LOW,
    S_POLL_HIGH
  } state_t;

  localparam logic [31:0]   STARTUP_LAST = 32'(STARTUP_CYCLES - 1);
  localparam logic [31:0]   POLL_LAST    = 32'(POLL_CYCLES - 1);
  localparam logic [AW-1:0] LAST_ADDR    = AW'(TABLE_DEPTH - 1);
  localparam logic [7:0]    MAX_TRIES    = 8'(MAX_RETRIES);
  localparam logic [7:0]    END_MARKER   = 8'hFF;

  state_t        state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [7:0]    reg_q, reg_d;
  logic [7:0]    val_q, val_d;
  logic [7:0]    retry_q, retry_d;
  logic          is_read_q, is_read_d;
  logic          ack_err_q, ack_err_d;
  logic          cfg_done_q, cfg_done_d;
  logic          cfg_err_q, cfg_err_d;
  logic          hpd_q, hpd_d;
  logic          pend_q, pend_d;
  logic          start_pass;
  logic          advance;

  // Only the hot-plug bit of the status register matters.
  logic unused_data_bits;
  assign unused_data_bits = ^{i2c_data[7], i2c_data[5:0]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_STARTUP;
      cnt_q      <= '0;
      rom_addr_q <= '0;
      reg_q      <= '0;
      val_q      <= '0;
      retry_q    <= '0;
      is_read_q  <= 1'b0;
      ack_err_q  <= 1'b0;
      cfg_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      hpd_q      <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rom_addr_q <= rom_addr_d;
      reg_q      <= reg_d;
      val_q      <= val_d;
      retry_q    <= retry_d;
      is_read_q  <= is_read_d;
      ack_err_q  <= ack_err_d;
      cfg_done_q <= cfg_done_d;
      cfg_err_q  <= cfg_err_d;
      hpd_q      <= hpd_d;
      pend_q     <= pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;           // counter only runs in the two waiting states
    rom_addr_d = rom_addr_q;
    reg_d      = reg_q;
    val_d      = val_q;
    retry_d    = retry_q;
    is_read_d  = is_read_q;
    ack_err_d  = ack_err_q;
    cfg_done_d = cfg_done_q;
    cfg_err_d  = cfg_err_q;
    hpd_d      = hpd_q;
    pend_d     = pend_q | restart;  // remembered until the next pass starts
    start_pass = 1'b0;
    advance    = 1'b0;

    case (state_q)
      S_STARTUP: begin
        if (cnt_q == STARTUP_LAST) start_pass = 1'b1;
        else                       cnt_d = cnt_q + 32'd1;
      end

      S_FETCH: state_d = S_FETCH_WAIT;

      S_FETCH_WAIT: begin
        if (rom_data[15:8] == END_MARKER) begin
          cfg_done_d = ~cfg_err_q;
          state_d    = S_POLL_WAIT;
        end else begin
          reg_d     = rom_data[15:8];
          val_d     = rom_data[7:0];
          retry_d   = '0;
          is_read_d = 1'b0;
          state_d   = S_ISSUE;
        end
      end

      S_ISSUE: state_d = S_WAIT_LOW;

      S_WAIT_LOW: if (!i2c_done) state_d = S_WAIT_HIGH;

      S_WAIT_HIGH: begin
        if (i2c_done) begin
          ack_err_d = i2c_ack_error;
          state_d   = S_CHECK;
        end
      end

      S_CHECK: begin
        if (!ack_err_q) begin
          advance = 1'b1;
        end else if ((retry_q + 8'd1) < MAX_TRIES) begin
          retry_d   = retry_q + 8'd1;
          is_read_d = 1'b0;
          state_d   = S_ISSUE;
        end else begin
          retry_d   = retry_q + 8'd1;
          cfg_err_d = 1'b1;
          advance   = 1'b1;
        end
        // The last table slot ends the pass as if an end marker followed,
        // so rom_addr never wraps back to 0 inside a pass.
        if (advance) begin
          if (rom_addr_q == LAST_ADDR) begin
            cfg_done_d = ~cfg_err_d;
            state_d    = S_POLL_WAIT;
          end else begin
            rom_addr_d = rom_addr_q + AW'(1);
            state_d    = S_FETCH;
          end
        end
      end

      S_POLL_WAIT: begin
        if (restart || pend_q) begin
          start_pass = 1'b1;
        end else if (cnt_q == POLL_LAST) begin
          is_read_d = 1'b1;
          state_d   = S_POLL_ISSUE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      S_POLL_ISSUE: state_d = S_POLL_LOW;

      S_POLL_LOW: if (!i2c_done) state_d = S_POLL_HIGH;

      S_POLL_HIGH: begin
        if (i2c_done) begin
          state_d = S_POLL_WAIT;
          if (!i2c_ack_error) begin
            hpd_d = i2c_data[6];
            if (!hpd_q && i2c_data[6]) start_pass = 1'b1;
          end
        end
      end

      default: state_d = S_STARTUP;
    endcase

    if (start_pass) begin
      state_d    = S_FETCH;
      rom_addr_d = '0;
      cfg_done_d = 1'b0;
      cfg_err_d  = 1'b0;
      pend_d     = 1'b0;
    end
  end

  assign rom_addr      = rom_addr_q;
  assign i2c_enable    = (state_q == S_ISSUE) || (state_q == S_POLL_ISSUE);
  assign i2c_is_read   = is_read_q;
  assign i2c_chip_addr = CHIP_ADDR;
  assign i2c_reg_addr  = is_read_q ? HPD_REG : reg_q;
  assign i2c_value     = val_q;
  assign config_done   = cfg_done_q;
  assign cfg_error     = cfg_err_q;
  assign hpd           = hpd_q;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Testbench for i2c_cfg_sequencer: a registered table ROM, a behavioural I2C
// block with programmable NACKs and poll data, table-driven pass vectors and
// hand-written hot-plug / restart / reset sequences.

module tb_i2c_cfg_sequencer;

  localparam int STARTUP = 10;
  localparam int POLL    = 20;
  localparam int DEPTH   = 4;
  localparam int BUS     = 3;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        restart = 1'b0;
  logic [1:0]  rom_addr;
  logic [15:0] rom_data = '0;
  logic        i2c_enable, i2c_is_read;
  logic [6:0]  i2c_chip_addr;
  logic [7:0]  i2c_reg_addr, i2c_value;
  logic        i2c_done = 1'b1;
  logic [7:0]  i2c_data = '0;
  logic        i2c_ack_error = 1'b0;
  logic        config_done, cfg_error, hpd;

  always #5 clk = ~clk;

  i2c_cfg_sequencer #(
    .CHIP_ADDR(7'h39), .TABLE_DEPTH(DEPTH), .MAX_RETRIES(3),
    .STARTUP_CYCLES(STARTUP), .POLL_CYCLES(POLL), .HPD_REG(8'h42)
  ) dut (
    .clk(clk), .reset(reset), .restart(restart),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .i2c_enable(i2c_enable), .i2c_is_read(i2c_is_read),
    .i2c_chip_addr(i2c_chip_addr), .i2c_reg_addr(i2c_reg_addr),
    .i2c_value(i2c_value), .i2c_done(i2c_done), .i2c_data(i2c_data),
    .i2c_ack_error(i2c_ack_error), .config_done(config_done),
    .cfg_error(cfg_error), .hpd(hpd)
  );

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];
  logic [15:0] w_log[$];
  int          wr_cnt = 0;
  int          rd_done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- table ROM (1-cycle latency) ----------------
  logic [15:0] rom_mem [DEPTH];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // ---------------- I2C block model ----------------
  logic [7:0]  nack_reg = 8'h00;
  int          nack_left = 0;       // 255 = NACK forever
  logic [7:0]  poll_data = 8'h00;
  int          busy = 0;
  logic [16:0] cur = '0;
  logic        nack_pend = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      i2c_done      <= 1'b1;
      i2c_ack_error <= 1'b0;
      i2c_data      <= 8'h00;
      busy = 0;
    end else if (busy != 0) begin
      busy--;
      if (busy == 0) begin
        check("hold_stable", {15'd0, i2c_is_read, i2c_reg_addr, i2c_value}, {15'd0, cur});
        i2c_done      <= 1'b1;
        i2c_ack_error <= nack_pend;
        i2c_data      <= cur[16] ? poll_data : 8'h00;
        if (cur[16]) rd_done_cnt++;
      end
    end else if (i2c_enable) begin
      cur = {i2c_is_read, i2c_reg_addr, i2c_value};
      busy = BUS;
      i2c_done <= 1'b0;
      nack_pend = 1'b0;
      if (!i2c_is_read && i2c_reg_addr == nack_reg && nack_left != 0) begin
        nack_pend = 1'b1;
        if (nack_left != 255) nack_left--;
      end
    end
  end

  // ---------------- request monitor ----------------
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (i2c_enable) begin
      check("en_when_idle", {31'd0, i2c_done}, 32'd1);
      check("en_one_cycle", {31'd0, prev_en}, 32'd0);
      check("chip_addr", {25'd0, i2c_chip_addr}, 32'h39);
      if (i2c_is_read) check("poll_reg", {24'd0, i2c_reg_addr}, 32'h42);
      else begin
        w_log.push_back({i2c_reg_addr, i2c_value});
        wr_cnt++;
      end
    end
    prev_en = i2c_enable;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_enable", {31'd0, i2c_enable}, 32'd0);
    check("rst_is_read", {31'd0, i2c_is_read}, 32'd0);
    check("rst_cfg_done", {31'd0, config_done}, 32'd0);
    check("rst_cfg_error", {31'd0, cfg_error}, 32'd0);
    check("rst_hpd", {31'd0, hpd}, 32'd0);
    check("rst_rom_addr", {30'd0, rom_addr}, 32'd0);
    w_log.delete();
    reset = 1'b1;
  endtask

  task automatic wait_read_done(input string tag);
    int start;
    int n;
    start = rd_done_cnt;
    n = 0;
    while (rd_done_cnt == start && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (rd_done_cnt == start) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout_%s: no poll completed within %0d cycles", tag, n);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic compare_log(input string tag);
    logic [15:0] e, a;
    check({tag, "_n_writes"}, w_log.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (w_log.size() > 0) ? w_log.pop_front() : 16'hDEAD;
      check({tag, "_write"}, {16'd0, a}, {16'd0, e});
    end
    w_log.delete();
  endtask

  // ---------------- vectors ----------------
  typedef struct packed {
    logic [0:3][15:0] rom;
    logic [7:0]       nack_reg;
    logic [7:0]       nack_cnt;
    logic [7:0]       n_exp;
    logic [0:5][15:0] exp_w;
    logic             exp_done;
    logic             exp_err;
  } vec_t;

  vec_t vecs [6];

  initial begin
    // table pass
    vecs[0] = '{rom: {16'h4110, 16'h9803, 16'hFF00, 16'h0000}, nack_reg: 8'h00, nack_cnt: 8'd0,
                n_exp: 8'd2, exp_w: {16'h4110, 16'h9803, 64'h0}, exp_done: 1'b1, exp_err: 1'b0};
    // recovered NACK on the first 0x98 attempt
    vecs[1] = '{rom: {16'h4110, 16'h9803, 16'hFF00, 16'h0000}, nack_reg: 8'h98, nack_cnt: 8'd1,
                n_exp: 8'd3, exp_w: {16'h4110, 16'h9803, 16'h9803, 48'h0}, exp_done: 1'b1, exp_err: 1'b0};
    // exhausted retries on 0x41, 0x98 still written
    vecs[2] = '{rom: {16'h4110, 16'h9803, 16'hFF00, 16'h0000}, nack_reg: 8'h41, nack_cnt: 8'd255,
                n_exp: 8'd4, exp_w: {16'h4110, 16'h4110, 16'h4110, 16'h9803, 32'h0}, exp_done: 1'b0, exp_err: 1'b1};
    // no end marker: full depth then polling
    vecs[3] = '{rom: {16'h1101, 16'h2202, 16'h3303, 16'h4404}, nack_reg: 8'h00, nack_cnt: 8'd0,
                n_exp: 8'd4, exp_w: {16'h1101, 16'h2202, 16'h3303, 16'h4404, 32'h0}, exp_done: 1'b1, exp_err: 1'b0};
    // no end marker, last slot exhausts its retries
    vecs[4] = '{rom: {16'h1101, 16'h2202, 16'h3303, 16'h4404}, nack_reg: 8'h44, nack_cnt: 8'd255,
                n_exp: 8'd6, exp_w: {16'h1101, 16'h2202, 16'h3303, 16'h4404, 16'h4404, 16'h4404},
                exp_done: 1'b0, exp_err: 1'b1};
    // end marker in the first slot
    vecs[5] = '{rom: {16'hFF00, 16'h4110, 16'h9803, 16'h0000}, nack_reg: 8'h00, nack_cnt: 8'd0,
                n_exp: 8'd0, exp_w: 96'h0, exp_done: 1'b1, exp_err: 1'b0};

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < DEPTH; i++) rom_mem[i] = vecs[v].rom[i];
      nack_reg  = vecs[v].nack_reg;
      nack_left = int'(vecs[v].nack_cnt);
      poll_data = 8'h00;
      do_reset();
      wait_read_done($sformatf("v%0d", v));
      for (int i = 0; i < int'(vecs[v].n_exp); i++) exp_q.push_back(vecs[v].exp_w[i]);
      compare_log($sformatf("v%0d", v));
      check($sformatf("v%0d_config_done", v), {31'd0, config_done}, {31'd0, vecs[v].exp_done});
      check($sformatf("v%0d_cfg_error", v), {31'd0, cfg_error}, {31'd0, vecs[v].exp_err});
      check($sformatf("v%0d_hpd", v), {31'd0, hpd}, 32'd0);
    end

    // ---------------- hot-plug ----------------
    rom_mem[0] = 16'h4110; rom_mem[1] = 16'h9803; rom_mem[2] = 16'hFF00; rom_mem[3] = 16'h0000;
    nack_left = 0;
    poll_data = 8'h00;
    do_reset();
    wait_read_done("hp_first");
    w_log.delete();
    wait_read_done("hp_low");
    check("hp_low_hpd", {31'd0, hpd}, 32'd0);
    compare_log("hp_low");
    poll_data = 8'h40;
    wait_read_done("hp_rise");
    check("hp_rise_hpd", {31'd0, hpd}, 32'd1);
    wait_read_done("hp_rerun");
    exp_q.push_back(16'h4110);
    exp_q.push_back(16'h9803);
    compare_log("hp_rerun");
    check("hp_rerun_done", {31'd0, config_done}, 32'd1);
    wait_read_done("hp_steady");
    compare_log("hp_steady");
    check("hp_steady_hpd", {31'd0, hpd}, 32'd1);

    // ---------------- restart mid-write ----------------
    poll_data = 8'h00;
    do_reset();
    begin
      int start, n;
      start = wr_cnt;
      n = 0;
      while (wr_cnt == start && n < 200) begin @(negedge clk); n++; end
      check("rs_first_write_seen", {31'd0, wr_cnt != start}, 32'd1);
    end
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    wait_read_done("restart");
    exp_q.push_back(16'h4110);
    exp_q.push_back(16'h9803);
    exp_q.push_back(16'h4110);
    exp_q.push_back(16'h9803);
    compare_log("restart");
    check("rs_config_done", {31'd0, config_done}, 32'd1);

    // ---------------- reset mid-transaction ----------------
    begin
      int n;
      n = 0;
      while (!(i2c_is_read && !i2c_done) && n < 200) begin @(negedge clk); n++; end
      check("rm_poll_in_flight", {31'd0, i2c_is_read && !i2c_done}, 32'd1);
    end
    reset = 1'b0;
    @(negedge clk);
    check("rm_enable", {31'd0, i2c_enable}, 32'd0);
    check("rm_config_done", {31'd0, config_done}, 32'd0);
    check("rm_is_read", {31'd0, i2c_is_read}, 32'd0);
    check("rm_rom_addr", {30'd0, rom_addr}, 32'd0);
    @(negedge clk);
    w_log.delete();
    reset = 1'b1;
    begin
      int n;
      n = 0;
      do begin
        @(posedge clk);
        n++;
        @(negedge clk);
      end while (!i2c_enable && n < 200);
      check("rm_startup_latency", n, STARTUP + 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
